// File: rtl/gf180mcu_nand3_stim_chk_if.sv
// Bundles the run-control handshake and the NAND3 cell stimulus/response wires.
// The checker uses the slave side. The harness or bench uses the master side.
interface gf180mcu_nand3_stim_chk_if;
    logic       START;
    logic       ZN_IN;
    logic       A1;
    logic       A2;
    logic       A3;
    logic       BUSY;
    logic       DONE;
    logic [7:0] ERR_MAP;
    logic       PASS;

    modport slave (
        input  START, ZN_IN,
        output A1, A2, A3, BUSY, DONE, ERR_MAP, PASS
    );

    modport master (
        output START, ZN_IN,
        input  A1, A2, A3, BUSY, DONE, ERR_MAP, PASS
    );
endinterface

// File: rtl/gf180mcu_nand3_stim_chk.sv
// Stimulus driver and ZN checker for a NAND3 cell. It steps through all eight
// input vectors and records mismatches in ERR_MAP, indexed by vector value.
// Optional macros: GF180MCU_NAND3_STIM_GRAY_EN selects Gray vector order.
// USE_POWER_PINS adds the VDD and VSS pins.
//
// state  | meaning
// S_IDLE | after reset, waiting for START
// S_RUN  | holding a vector, then sampling ZN_IN when the settle count expires
// S_DONE | run finished, ERR_MAP valid, START re-arms
module gf180mcu_nand3_stim_chk #(
    parameter int SETTLE_CYCLES = 2
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    gf180mcu_nand3_stim_chk_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] a_q, a_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] err_map_q, err_map_d;

    function automatic logic [2:0] seq(input logic [2:0] i);
`ifdef GF180MCU_NAND3_STIM_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_map_d = err_map_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_map_d = 8'h00;
                    idx_d     = 3'd0;
                    a_d       = seq(3'd0);
                    cnt_d     = SETTLE_LD;
                end
            end
            S_RUN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Case inequality, so an X or Z on ZN_IN also counts as a miss.
                    if (bus.ZN_IN !== ~(&a_q)) begin
                        err_map_d[a_q] = 1'b1;
                    end
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        a_d   = seq(idx_q + 3'd1);
                        cnt_d = SETTLE_LD;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = 3'b000;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            a_q       <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_map_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_map_q <= err_map_d;
        end
    end

    assign bus.A1      = a_q[0];
    assign bus.A2      = a_q[1];
    assign bus.A3      = a_q[2];
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR_MAP = err_map_q;
    assign bus.PASS    = done_q & (err_map_q == 8'h00);

endmodule
